multicycle_control_unit: RTL and testbench

Finite-state controller for the multicycle RV32I datapath. It is the successor to the single-cycle control unit. It sequences fetch, decode, execute, memory and writeback over several cycles and decodes the full RV32I ALU and branch set (4-bit ALU control, all six branch conditions, LUI, AUIPC, JALR). It stalls on a memory-ready handshake and traps on illegal opcodes. It sits between the instruction register/ALU flags and every multicycle datapath mux and write enable.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/alu_decoder_ext.sv | 38 +++
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR_T, S_JAL, S_LUI, S_AUIPC, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder_ext.sv
// Maps the controller's ALU op class plus funct3/funct7b5 onto the ALU code.
module alu_decoder_ext
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  alu_op_e               alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] code;

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      default: begin
        case (funct3)
          // bit 30 of an I-type add is immediate data, so only R-type subtracts
          3'b000:  code = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I controller: state register, next-state logic and a
// combinational output decode driving every datapath mux and enable.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter bit          EN_MEM_WAIT = 1'b1,
  parameter int unsigned ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  if (ALU_CTRL_W < 4) begin : g_bad_width
    $error("multicycle_control_unit: ALU_CTRL_W must be at least 4");
  end

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    ready;
  logic    taken;
  logic    bad_branch;

  assign ready      = EN_MEM_WAIT ? mem_ready : 1'b1;
  assign bad_branch = (funct3 == 3'b010) || (funct3 == 3'b011);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_T;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = bad_branch ? S_TRAP : S_FETCH;
      S_JALR_T:   state_d = S_JAL;
      S_JAL,
      S_LUI,
      S_AUIPC:    state_d = S_ALUWB;
      default:    state_d = S_TRAP;
    endcase
  end

  // Reset gates the decode so no strobe escapes while the state is reloading.
  always_comb begin
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            result_src = RES_ALU;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = RES_DATA;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_RTYPE;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ITYPE;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_write  = taken && !bad_branch;
        end
        S_JALR_T: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_JAL: begin
          pc_write  = 1'b1;
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
        end
        S_LUI: begin
          alu_src_a = SRCA_ZERO;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        S_AUIPC: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        default:  illegal = 1'b1;
      endcase
    end
  end

  alu_decoder_ext #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized check of the multicycle controller against an instruction-level
// model that expands each instruction into its expected per-cycle outputs.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset, mem_ready, zero, lt, ltu, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_req, pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic       mem_req, pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] res, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    exp_t rdy;
    exp_t wt;
    logic is_mem;
  } step_t;

  step_t sq[$];
  string tq[$];
  bit    trap_pending;
  int    forced_wait = -1;

  multicycle_control_unit #(
    .EN_MEM_WAIT (1'b1),
    .ALU_CTRL_W  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .lt          (lt),
    .ltu         (ltu),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.mem_req = mem_req;   o.pc_write = pc_write;   o.adr_src = adr_src;
    o.ir_write = ir_write; o.mem_write = mem_write; o.reg_write = reg_write;
    o.res = result_src;    o.sa = alu_src_a;        o.sb = alu_src_b;
    o.imm = imm_src;       o.alu = alu_control;     o.illegal = illegal;
    return o;
  endfunction

  function automatic logic [3:0] alu_code(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      3'd7:    return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                     7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push(input string t, input exp_t r, input exp_t w, input logic m);
    step_t s;
    s.rdy = r; s.wt = w; s.is_mem = m;
    sq.push_back(s);
    tq.push_back(t);
  endtask

  task automatic push_wb();
    exp_t e = '0;
    e.reg_write = 1'b1;
    push("aluwb", e, e, 1'b0);
  endtask

  task automatic push_jal();
    exp_t e = '0;
    e.pc_write = 1'b1; e.sa = 2'd1; e.sb = 2'd2;
    push("jal", e, e, 1'b0);
  endtask

  // Expand one instruction into the output sequence its class implies.
  task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input logic lu);
    exp_t e, w;
    trap_pending = 1'b0;
    e = '0; e.mem_req = 1'b1; e.sb = 2'd2; w = e;
    e.ir_write = 1'b1; e.pc_write = 1'b1; e.res = 2'd2;
    push("fetch", e, w, 1'b1);
    e = '0; e.sa = 2'd1; e.sb = 2'd1; e.imm = (o == 7'b1101111) ? 3'd3 : 3'd2;
    push("decode", e, e, 1'b0);
    case (o)
      7'b0000011: begin
        e = '0; e.sa = 2'd2; e.sb = 2'd1; push("memadr_ld", e, e, 1'b0);
        e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; push("memread", e, e, 1'b1);
        e = '0; e.reg_write = 1'b1; e.res = 2'd1; push("memwb", e, e, 1'b0);
      end
      7'b0100011: begin
        e = '0; e.sa = 2'd2; e.sb = 2'd1; e.imm = 3'd1; push("memadr_st", e, e, 1'b0);
        e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1;
        push("memwrite", e, e, 1'b1);
      end
      7'b0110011: begin
        e = '0; e.sa = 2'd2; e.alu = alu_code(1'b1, f3, f7); push("execr", e, e, 1'b0);
        push_wb();
      end
      7'b0010011: begin
        e = '0; e.sa = 2'd2; e.sb = 2'd1; e.alu = alu_code(1'b0, f3, f7);
        push("execi", e, e, 1'b0);
        push_wb();
      end
      7'b1100011: begin
        e = '0; e.sa = 2'd2; e.alu = 4'd1;
        if (f3 == 3'd2 || f3 == 3'd3) trap_pending = 1'b1;
        else e.pc_write = branch_taken(f3, z, l, lu);
        push("branch", e, e, 1'b0);
      end
      7'b1101111: begin
        push_jal();
        push_wb();
      end
      7'b1100111: begin
        e = '0; e.sa = 2'd2; e.sb = 2'd1; push("jalr_t", e, e, 1'b0);
        push_jal();
        push_wb();
      end
      7'b0110111: begin
        e = '0; e.sa = 2'd3; e.sb = 2'd1; e.imm = 3'd4; push("lui", e, e, 1'b0);
        push_wb();
      end
      7'b0010111: begin
        e = '0; e.sa = 2'd1; e.sb = 2'd1; e.imm = 3'd4; push("auipc", e, e, 1'b0);
        push_wb();
      end
      default: trap_pending = 1'b1;
    endcase
  endtask

  task automatic cycle(input string tag, input exp_t e, input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    check_eq(tag, 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_step();
    step_t s = sq.pop_front();
    string t = tq.pop_front();
    int    n;
    if (s.is_mem) begin
      n = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 2));
      repeat (n) cycle({t, "_wait"}, s.wt, 1'b0);
      cycle(t, s.rdy, 1'b1);
    end else begin
      cycle(t, s.rdy, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("reset_strobes", 32'({mem_req, pc_write, ir_write, mem_write, reg_write, illegal}), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic l, input logic lu);
    exp_t tr = '0;
    tr.illegal = 1'b1;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
    model(o, f3, f7, z, l, lu);
    while (sq.size() > 0) run_step();
    if (trap_pending) begin
      repeat (10) cycle("trap", tr, 1'($urandom_range(0, 1)));
      do_reset(1);
    end
  endtask

  task automatic run_random();
    logic [6:0] o;
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    int unsigned k = $urandom_range(0, 19);
    case (k)
      0, 1:     o = 7'b0000011;
      2, 3:     o = 7'b0100011;
      4, 5, 6:  o = 7'b0110011;
      7, 8, 9:  o = 7'b0010011;
      10, 11:   o = 7'b1100011;
      12:       o = 7'b1101111;
      13:       o = 7'b1100111;
      14:       o = 7'b0110111;
      15:       o = 7'b0010111;
      16: begin
        o = 7'b0000000;
        for (int i = 0; i < 50; i++) begin
          o = 7'($urandom_range(0, 127));
          if (!is_legal(o)) break;
        end
        if (is_legal(o)) o = 7'b1111111;
      end
      17: begin
        o  = 7'b1100011;
        f3 = 3'(2 + $urandom_range(0, 1));
      end
      default: begin
        o  = 7'b1100011;
        f3 = 3'($urandom_range(4, 7));
      end
    endcase
    run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    exp_t w;
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    do_reset(2);

    forced_wait = 0;
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // add
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);  // bne taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);  // bne not taken
    run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // jalr
    forced_wait = 2;
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);  // lw with waits
    forced_wait = 0;
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // illegal opcode

    // Reset arriving while a store waits on memory.
    op = 7'b0100011; funct3 = 3'd2;
    model(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) run_step();
    w = sq[0].wt;
    cycle("memwrite_wait", w, 1'b0);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sq.delete();
    tq.delete();
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);  // sub from clean fetch

    forced_wait = -1;
    for (int i = 0; i < 300; i++) run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
